// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier, the product accumulator and its consumer.
// Latency: none (wires only).
// Backpressure: in_ready toward the producer, out_ready from the consumer.
// Ports: clear, in_valid/in_ready/in_product (product side), out_valid/out_ready/
//        out_sum/out_overflow (result side), term_count (status).
// slave = accumulator view, master = producer/consumer view.
interface product_accumulator_if #(
   parameter int ACC_WIDTH = 16,
   parameter int TERMS     = 4
);
   localparam int CNT_W = $clog2(TERMS) + 1;

   logic                 clear;
   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           in_product;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_sum;
   logic                 out_overflow;
   logic [CNT_W-1:0]     term_count;

   modport slave (
      input  clear, in_valid, in_product, out_ready,
      output in_ready, out_valid, out_sum, out_overflow, term_count
   );

   modport master (
      output clear, in_valid, in_product, out_ready,
      input  in_ready, out_valid, out_sum, out_overflow, term_count
   );
endinterface

// File: rtl/product_accumulator.sv
// Sums TERMS consecutive 8-bit products into an ACC_WIDTH result with overflow flag.
// Latency: out_valid rises 1 cycle after the final product is accepted.
// Backpressure: in_ready drops while a result is held; result held until out_ready.
// Ports: clk, rst_n (synchronous, active-low), bus (product_accumulator_if.slave).
// Build option: PRODUCT_ACC_SATURATE_EN clamps the accumulator at all-ones on carry-out
// instead of wrapping; out_overflow is reported the same way in both builds.
module product_accumulator #(
   parameter int ACC_WIDTH = 16,
   parameter int TERMS     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   product_accumulator_if.slave   bus
);
   localparam int CNT_W = $clog2(TERMS) + 1;

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;          // sticky carry for the result in progress
   logic                 out_ovf_q, out_ovf_d;
   logic                 vld_q, vld_d;

   logic [ACC_WIDTH:0]   add_full;
   logic                 carry;
   logic [ACC_WIDTH-1:0] add_res;
   logic                 last_term;
   logic                 in_rdy;

   // One extra bit on the adder exposes the carry-out used for overflow.
   assign add_full  = {1'b0, acc_q} + {{(ACC_WIDTH - 7){1'b0}}, bus.in_product};
   assign carry     = add_full[ACC_WIDTH];
   assign last_term = (cnt_q == CNT_W'(TERMS - 1));

`ifdef PRODUCT_ACC_SATURATE_EN
   // Once clamped, any further carry re-clamps, so the value sticks at all-ones.
   assign add_res = carry ? {ACC_WIDTH{1'b1}} : add_full[ACC_WIDTH-1:0];
`else
   assign add_res = add_full[ACC_WIDTH-1:0];
`endif

   // clear gates in_ready so a product offered during clear is never consumed.
   assign in_rdy = (state_q == ACCUM) && !bus.clear;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      out_ovf_d = out_ovf_q;
      vld_d     = vld_q;
      case (state_q)
         ACCUM: begin
            if (bus.clear) begin
               acc_d = '0;
               cnt_d = '0;
               ovf_d = 1'b0;
            end else if (bus.in_valid) begin
               acc_d = add_res;
               cnt_d = cnt_q + CNT_W'(1);
               ovf_d = ovf_q | carry;
               if (last_term) begin
                  sum_d     = add_res;
                  out_ovf_d = ovf_q | carry;
                  vld_d     = 1'b1;
                  state_d   = HOLD;
               end
            end
         end
         HOLD: begin
            // clear is deliberately ignored here: a pending result is never dropped.
            if (bus.out_ready) begin
               vld_d   = 1'b0;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         out_ovf_q <= 1'b0;
         vld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         out_ovf_q <= out_ovf_d;
         vld_q     <= vld_d;
      end
   end

   assign bus.in_ready     = in_rdy;
   assign bus.out_valid    = vld_q;
   assign bus.out_sum      = sum_q;
   assign bus.out_overflow = out_ovf_q;
   assign bus.term_count   = cnt_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 16-bit and a 9-bit instance share all stimulus.
// Latency: checks each cycle 1 time unit after the rising edge.
// Backpressure: exercised via randomized and directed out_ready patterns.
module tb_product_accumulator;
   localparam int TERMS = 4;

`ifdef PRODUCT_ACC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   product_accumulator_if #(.ACC_WIDTH(16), .TERMS(TERMS)) bus16 ();
   product_accumulator_if #(.ACC_WIDTH(9),  .TERMS(TERMS)) bus9 ();

   assign bus9.clear      = bus16.clear;
   assign bus9.in_valid   = bus16.in_valid;
   assign bus9.in_product = bus16.in_product;
   assign bus9.out_ready  = bus16.out_ready;

   product_accumulator #(.ACC_WIDTH(16), .TERMS(TERMS)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   product_accumulator #(.ACC_WIDTH(9), .TERMS(TERMS)) dut9 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus9)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: list of products for the result being built plus the last result.
   bit          m_known = 1'b0;
   bit          m_hold  = 1'b0;
   int unsigned m_q[$];
   int unsigned exp16 = 0, exp9 = 0;
   bit          eovf16 = 1'b0, eovf9 = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  tag, act, act, exp, exp, $time);
      end
   endtask

   // Partial sums only grow, so overflow happens iff the total exceeds the width;
   // saturation then yields all-ones, wrapping yields the total modulo 2^w.
   function automatic int unsigned ref_sum(input int unsigned total, input int w);
      int unsigned lim = 32'd1 << w;
      if (total < lim) return total;
      return SAT ? (lim - 1) : (total % lim);
   endfunction

   task automatic cycle(input bit rst, input bit v, input int unsigned p,
                        input bit clr, input bit ordy);
      int unsigned total;
      rst_n            = !rst;
      bus16.in_valid   = v;
      bus16.in_product = 8'(p);
      bus16.clear      = clr;
      bus16.out_ready  = ordy;
      #1;
      if (m_known) begin
         chk("in_ready16", 32'(bus16.in_ready), 32'(!m_hold && !clr));
         chk("in_ready9",  32'(bus9.in_ready),  32'(!m_hold && !clr));
      end
      if (rst) begin
         m_known = 1'b1;
         m_hold  = 1'b0;
         m_q.delete();
         exp16 = 0; exp9 = 0; eovf16 = 1'b0; eovf9 = 1'b0;
      end else if (m_hold) begin
         if (ordy) m_hold = 1'b0;
      end else if (clr) begin
         m_q.delete();
      end else if (v) begin
         m_q.push_back(p & 32'hFF);
         if (m_q.size() == TERMS) begin
            total = 0;
            foreach (m_q[i]) total += m_q[i];
            exp16  = ref_sum(total, 16);
            eovf16 = (total >= 32'd65536);
            exp9   = ref_sum(total, 9);
            eovf9  = (total >= 32'd512);
            m_hold = 1'b1;
            m_q.delete();
         end
      end
      @(posedge clk);
      #1;
      if (m_known) begin
         chk("out_valid16",  32'(bus16.out_valid),    32'(m_hold));
         chk("out_valid9",   32'(bus9.out_valid),     32'(m_hold));
         chk("term_count16", 32'(bus16.term_count),   m_hold ? TERMS : m_q.size());
         chk("term_count9",  32'(bus9.term_count),    m_hold ? TERMS : m_q.size());
         chk("out_sum16",    32'(bus16.out_sum),      exp16);
         chk("out_sum9",     32'(bus9.out_sum),       exp9);
         chk("out_ovf16",    32'(bus16.out_overflow), 32'(eovf16));
         chk("out_ovf9",     32'(bus9.out_overflow),  32'(eovf9));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus16.in_valid = 1'b0; bus16.in_product = 8'd0;
      bus16.clear = 1'b0; bus16.out_ready = 1'b0;
      @(posedge clk); #1;

      // Reset for two edges, then release.
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      chk("rst_out_valid", 32'(bus16.out_valid), 0);
      chk("rst_out_sum",   32'(bus16.out_sum), 0);
      chk("rst_term_cnt",  32'(bus16.term_count), 0);

      // Basic sum, then 5 cycles of backpressure, then a single-cycle handshake.
      for (int i = 0; i < 4; i++) cycle(0, 1, 225, 0, 0);
      chk("basic_sum16", 32'(bus16.out_sum), 900);
      chk("basic_ovf16", 32'(bus16.out_overflow), 0);
      for (int i = 0; i < 5; i++) cycle(0, 1, 7, 0, 0);
      cycle(0, 0, 0, 0, 1);
      chk("hs_in_ready", 32'(bus16.in_ready), 1);

      // Overflow: 255 x4 overflows the 9-bit instance only.
      for (int i = 0; i < 4; i++) cycle(0, 1, 255, 0, 0);
      chk("ovf_sum9", 32'(bus9.out_sum), SAT ? 511 : 508);
      chk("ovf_flag9", 32'(bus9.out_overflow), 1);
      cycle(0, 0, 0, 0, 1);

      // Clear mid-accumulation, then fresh sum; clear during HOLD is ignored.
      cycle(0, 1, 10, 0, 0);
      cycle(0, 1, 20, 0, 0);
      cycle(0, 1, 99, 1, 0);
      for (int i = 1; i <= 4; i++) cycle(0, 1, i, 0, 0);
      chk("clear_sum16", 32'(bus16.out_sum), 10);
      for (int i = 0; i < 3; i++) cycle(0, 1, 50, 1, 0);
      cycle(0, 0, 0, 1, 1);

      // Reset while holding a result, then a fresh sum.
      for (int i = 0; i < 4; i++) cycle(0, 1, 100 + i, 0, 0);
      cycle(1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 60 * (i + 1), 0, 0);
      chk("post_rst_sum16", 32'(bus16.out_sum), 600);
      cycle(0, 0, 0, 0, 1);

      // Randomized traffic with gaps, clears, backpressure and rare resets.
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 149) == 0,
               $urandom_range(0, 3) != 0,
               ($urandom_range(0, 1) != 0) ? $urandom_range(200, 255) : $urandom_range(0, 255),
               $urandom_range(0, 11) == 0,
               $urandom_range(0, 2) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
